// File: rtl/flag_status_unit_pkg.sv
// rtl/flag_status_unit_pkg.sv - shared condition codes, flag indices and tracker state type
package flag_status_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NO = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    MFT_IDLE = 1'b0,
    MFT_BUSY = 1'b1
  } mft_state_e;

endpackage

// File: rtl/flag_status_unit_mul_flag_tracker.sv
// rtl/flag_status_unit_mul_flag_tracker.sv - multiply flag-write tracker: busy flag and retire pulse
module mul_flag_tracker
  import flag_status_unit_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_issue,
  output logic o_busy,
  output logic o_done
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MUL_LAT - 1);

  mft_state_e       r_state;
  mft_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MFT_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Counter runs regardless of pipeline stall; issue requests while busy are dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    case (r_state)
      MFT_IDLE: begin
        if (i_issue) begin
          w_state_nxt = MFT_BUSY;
          w_cnt_nxt   = LAT_M1;
        end
      end
      MFT_BUSY: begin
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = MFT_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = MFT_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_busy = (r_state == MFT_BUSY);
  assign o_done = w_done;

endmodule

// File: rtl/flag_status_unit.sv
// rtl/flag_status_unit.sv - NZCV status register, write mux, flag hazard and forwarding
// Optional EXE flag forwarding enabled by defining FLAG_FWD_EN.
module flag_status_unit
  import flag_status_unit_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       exe_valid,
  input  logic       exe_s,
  input  logic       exe_mul_s,
  input  logic       exe_cond_pass,
  input  logic [3:0] exe_flags,
  input  logic [1:0] mul_nz,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       id_s,
  output logic [3:0] sr,
  output logic [3:0] sr_fwd,
  output logic       hazard_stall,
  output logic       busy
);

  logic [3:0] r_sr;
  logic       w_exe_fire;
  logic       w_alu_wr;
  logic       w_mul_iss;
  logic       w_mul_done;
  logic       w_busy;
  logic       w_pend;
  logic       w_cond_rd;
  logic       w_alu_haz;

  // Gating with rst_n keeps the combinational outputs quiet while reset is held.
  assign w_exe_fire = rst_n & exe_valid & ~stall & exe_cond_pass;
  assign w_alu_wr   = w_exe_fire & exe_s & ~exe_mul_s;
  assign w_mul_iss  = w_exe_fire & exe_mul_s;

  mul_flag_tracker #(
    .MUL_LAT (MUL_LAT),
    .CNT_W   (CNT_W)
  ) u_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_issue (w_mul_iss),
    .o_busy  (w_busy),
    .o_done  (w_mul_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= 4'b0000;
    end else if (w_alu_wr) begin
      r_sr <= exe_flags;
    end else if (w_mul_done) begin
      r_sr <= {mul_nz, r_sr[FLAG_C:FLAG_V]};
    end
  end

  assign w_pend    = w_busy | w_mul_iss;
  assign w_cond_rd = (id_cond != COND_AL);

`ifdef FLAG_FWD_EN
  assign w_alu_haz = 1'b0;
  assign sr_fwd    = w_alu_wr ? exe_flags : r_sr;
`else
  assign w_alu_haz = w_alu_wr & w_cond_rd;
  assign sr_fwd    = r_sr;
`endif

  assign hazard_stall = rst_n & id_valid & ((w_pend & (w_cond_rd | id_s)) | w_alu_haz);
  assign sr           = r_sr;
  assign busy         = w_busy;

  a_no_alu_at_retire : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_alu_wr && w_mul_done));
  a_no_issue_busy : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_mul_iss && w_busy));

endmodule

// File: doc/flag_status_unit.md
Name: flag_status_unit

Overview:
- Owns the architectural NZCV status register. Feeds `sr` to the downstream condition evaluator in ID.
- Accepts flag writes from two producers: single-cycle ALU ops in EXE (S bit set), and flag-setting multiplies that complete MUL_LAT cycles after leaving EXE.
- Generates the flag-hazard stall for ID and, optionally, forwards EXE flags.

Parameters:
- MUL_LAT, 3, cycles from multiply leaving EXE to `mul_nz` being valid; legal range 1..15.
- CNT_W, 4, width of the multiply latency counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  pipeline freeze; EXE instruction holds.
- exe_valid  in  1  EXE holds a live instruction.
- exe_s  in  1  EXE ALU instruction sets flags.
- exe_mul_s  in  1  EXE is a flag-setting multiply.
- exe_cond_pass  in  1  EXE instruction's condition passed.
- exe_flags  in  4  ALU flags {N,Z,C,V}.
- mul_nz  in  2  multiply {N,Z}, valid on completion cycle.
- id_valid  in  1  ID holds a live instruction (low when flushed).
- id_cond  in  4  ID condition field.
- id_s  in  1  ID instruction will set flags (ALU or multiply).
- sr  out  4  registered {N,Z,C,V}; bit3=N, bit0=V.
- sr_fwd  out  4  flags for the condition evaluator (bypassed).
- hazard_stall  out  1  hold ID/IF this cycle.
- busy  out  1  multiply flag write outstanding.

Behaviour:
- Reset (async, rst_n=0):
  - sr=4'b0000, FSM=IDLE, cnt=0.
  - Outputs: busy=0, hazard_stall=0, sr_fwd=0.
- Fire qualifier: exe_fire = exe_valid & ~stall & exe_cond_pass.
- ALU write:
  - alu_wr = exe_fire & exe_s & ~exe_mul_s.
  - Next edge: sr <= exe_flags.
- Multiply issue:
  - mul_iss = exe_fire & exe_mul_s, only honoured in IDLE.
  - IDLE -> BUSY, cnt <= MUL_LAT-1.
- BUSY state:
  - cnt decrements every cycle, independent of stall.
  - When cnt==0: sr <= {mul_nz, sr[1:0]} (C,V preserved), FSM -> IDLE.
  - With MUL_LAT=1, BUSY lasts exactly one cycle.
- busy = (FSM==BUSY).
- Write ordering:
  - A simultaneous alu_wr and multiply completion cannot occur; hazard_stall prevents it.
  - If it does occur, the ALU write wins and an assertion fires in simulation.
  - mul_iss while BUSY is illegal; it is ignored and an assertion fires.
- Hazard:
  - pend = busy | mul_iss.
  - hazard_stall = id_valid & pend & (id_cond != 4'b1110 | id_s).
  - Both conditional readers and younger flag writers are held until the multiply retires.
  - hazard_stall stays high through the completion cycle and drops the cycle after, when sr holds the new value.
- Stall:
  - While stall=1, no ALU write and no issue occur.
  - The pending multiply still counts down and retires.
- Flush: handled via id_valid=0, which forces hazard_stall=0. sr and the FSM are not affected.
- sr_fwd: defined under the optional feature.
- Reset mid-BUSY: pending write is discarded, sr=0.

Optional Feature:
- Macro: FLAG_FWD_EN.
- Defined:
  - sr_fwd = alu_wr ? exe_flags : sr.
  - No stall for ALU flag producers.
- Undefined:
  - sr_fwd = sr.
  - hazard_stall additionally asserts when id_valid & alu_wr & id_cond != 4'b1110, costing one bubble per dependent conditional.

Decomposition:
- Shared package holds:
  - Condition code constants: EQ..NO, AL=4'b1110, HI=4'b1000.
  - Flag bit index constants: N=3, Z=2, C=1, V=0.
  - FSM state typedef {IDLE, BUSY}.
- Sub-module: mul_flag_tracker (FSM plus down-counter; outputs busy and a completion pulse).
- Top level holds the sr register, write mux, hazard and forward logic.

Test Plan:
- Reset: assert rst_n=0 mid-BUSY -> sr=0, busy=0, hazard_stall=0 with no clock edge required.
- ALU write: exe_s=1, exe_cond_pass=1, exe_flags=4'b0110 -> sr=4'b0110 next edge. With FLAG_FWD_EN, the same cycle gives sr_fwd=4'b0110 and hazard_stall=0 for id_cond=EQ. Without it, hazard_stall=1 for one cycle.
- Multiply retire: MUL_LAT=3, sr=4'b0011, issue MULS, mul_nz=2'b10 at completion -> busy high 3 cycles, then sr=4'b1011. id_cond=GE is stalled 4 cycles total.
- Non-blocking: with busy=1, id_cond=AL and id_s=0 -> hazard_stall=0. Then set id_s=1 -> hazard_stall=1.
- Stall during BUSY: stall=1 throughout -> multiply still retires after 3 cycles. exe_s held with stall=1 -> sr unchanged.
- Condition failed: exe_cond_pass=0 with exe_s=1 or exe_mul_s=1 -> sr unchanged, busy stays 0. Separately, id_valid=0 with busy=1 -> hazard_stall=0.
